// File: rtl/ovc_status_ctrl_if.sv
// Bundle between an output port's credit channel and its OVC status controller.
// The VC/switch allocators read the flags; the credit channel and allocators drive the pulses.
interface ovc_status_ctrl_if #(
    parameter int unsigned V     = 4,
    parameter int unsigned CRDTw = 3
);
    logic [V*CRDTw-1:0] credit_init_val;
    logic [V-1:0]       hetero_ovc_presence;
    logic [V-1:0]       credit_in;
    logic [V-1:0]       buff_space_decreased;
    logic [V-1:0]       ovc_is_allocated;
    logic [V-1:0]       ovc_is_released;

    logic [V*CRDTw-1:0] credit;
    logic [V-1:0]       ovc_status;
    logic [V-1:0]       ovc_avalable;
    logic [V-1:0]       full;
    logic [V-1:0]       nearly_full;
    logic [V-1:0]       empty;
    logic               init_done;
    logic [2:0]         err;

    modport master (
        output credit_init_val, hetero_ovc_presence, credit_in,
               buff_space_decreased, ovc_is_allocated, ovc_is_released,
        input  credit, ovc_status, ovc_avalable, full, nearly_full,
               empty, init_done, err
    );

    modport slave (
        input  credit_init_val, hetero_ovc_presence, credit_in,
               buff_space_decreased, ovc_is_allocated, ovc_is_released,
        output credit, ovc_status, ovc_avalable, full, nearly_full,
               empty, init_done, err
    );
endinterface

// File: rtl/ovc_status_ctrl.sv
// Per-output-port OVC controller: downstream credit tracking, OVC allocated/free
// status and the availability flags used by the VC/switch allocators.
module ovc_status_ctrl #(
    parameter int unsigned V              = 4,
    parameter int unsigned B              = 4,
    parameter int unsigned CRDTw          = ($clog2(B + 1) < 1) ? 1 : $clog2(B + 1),
    parameter int unsigned OVC_ALLOC_MODE = 1
) (
    input  logic                clk,
    input  logic                reset,
    ovc_status_ctrl_if.slave    bus
);

    localparam int unsigned ERRw = 3;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CRDTw-1:0]    credit_q [V];
    logic [CRDTw-1:0]    credit_d [V];
    logic [CRDTw-1:0]    cap_q    [V];
    logic [CRDTw-1:0]    cap_d    [V];
    logic [V-1:0]        status_q, status_d;
    logic [ERRw-1:0]     err_q, err_d;

    logic                run_c;
    logic [V-1:0]        full_c;
    logic [V-1:0]        nearly_full_c;
    logic [V-1:0]        empty_c;
    logic [V-1:0]        avail_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one RST cycle, one INIT cycle, then RUN until reset
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RST:  state_d = ST_INIT;
            ST_INIT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RST;
        endcase
    end

    assign run_c = (state_q == ST_RUN);

    // Flags decode from registered state only
    always_comb begin
        full_c        = '0;
        nearly_full_c = '0;
        empty_c       = '0;
        avail_c       = '0;
        for (int i = 0; i < V; i++) begin
            full_c[i]        = (credit_q[i] == '0);
            nearly_full_c[i] = (credit_q[i] <= CRDTw'(1));
            empty_c[i]       = (credit_q[i] == cap_q[i]);
            avail_c[i]       = run_c & bus.hetero_ovc_presence[i] & ~status_q[i] &
                               ((OVC_ALLOC_MODE != 0) ? ~full_c[i] : ~nearly_full_c[i]);
        end
    end

    // Credit, cap, status and error next-state
    always_comb begin
        credit_d = credit_q;
        cap_d    = cap_q;
        status_d = status_q;
        err_d    = err_q;
        unique case (state_q)
            ST_RST: begin
                for (int i = 0; i < V; i++) begin
                    credit_d[i] = '0;
                    cap_d[i]    = '0;
                end
                status_d = '0;
                err_d    = '0;
            end
            ST_INIT: begin
                // Absent OVCs get no credit; a zero advertisement means default depth
                for (int i = 0; i < V; i++) begin
                    if (!bus.hetero_ovc_presence[i]) begin
                        cap_d[i] = '0;
                    end else if (bus.credit_init_val[i*CRDTw +: CRDTw] == '0) begin
                        cap_d[i] = CRDTw'(B);
                    end else begin
                        cap_d[i] = bus.credit_init_val[i*CRDTw +: CRDTw];
                    end
                    credit_d[i] = cap_d[i];
                end
            end
            ST_RUN: begin
                for (int i = 0; i < V; i++) begin
                    if (bus.credit_in[i] && !bus.buff_space_decreased[i]) begin
                        if (credit_q[i] == cap_q[i]) begin
                            err_d[1] = 1'b1;
                        end else begin
                            credit_d[i] = credit_q[i] + CRDTw'(1);
                        end
                    end else if (bus.buff_space_decreased[i] && !bus.credit_in[i]) begin
                        if (credit_q[i] == '0) begin
                            err_d[0] = 1'b1;
                        end else begin
                            credit_d[i] = credit_q[i] - CRDTw'(1);
                        end
                    end

                    // Allocate beats release so a back-to-back packet keeps the OVC
                    if (bus.ovc_is_allocated[i]) begin
                        status_d[i] = 1'b1;
                        if (!avail_c[i]) begin
                            err_d[2] = 1'b1;
                        end
                    end else if (bus.ovc_is_released[i]) begin
                        status_d[i] = 1'b0;
                    end
                end
            end
            default: begin
                status_d = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < V; i++) begin
                credit_q[i] <= '0;
                cap_q[i]    <= '0;
            end
            status_q <= '0;
            err_q    <= '0;
        end else begin
            credit_q <= credit_d;
            cap_q    <= cap_d;
            status_q <= status_d;
            err_q    <= err_d;
        end
    end

    for (genvar g = 0; g < V; g++) begin : g_credit_out
        assign bus.credit[g*CRDTw +: CRDTw] = credit_q[g];
    end

    assign bus.ovc_status   = status_q;
    assign bus.ovc_avalable = avail_c;
    assign bus.full         = full_c;
    assign bus.nearly_full  = nearly_full_c;
    assign bus.empty        = empty_c;
    assign bus.init_done    = run_c;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_ovc_status_ctrl.sv
// Directed bench for ovc_status_ctrl: one DUT per allocation mode, shared stimulus.
module tb_ovc_status_ctrl;

    localparam int unsigned V     = 4;
    localparam int unsigned B     = 4;
    localparam int unsigned CRDTw = 3;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    ovc_status_ctrl_if #(.V(V), .CRDTw(CRDTw)) bus0 ();
    ovc_status_ctrl_if #(.V(V), .CRDTw(CRDTw)) bus1 ();

    assign bus1.credit_init_val      = bus0.credit_init_val;
    assign bus1.hetero_ovc_presence  = bus0.hetero_ovc_presence;
    assign bus1.credit_in            = bus0.credit_in;
    assign bus1.buff_space_decreased = bus0.buff_space_decreased;
    assign bus1.ovc_is_allocated     = bus0.ovc_is_allocated;
    assign bus1.ovc_is_released      = bus0.ovc_is_released;

    ovc_status_ctrl #(.V(V), .B(B), .CRDTw(CRDTw), .OVC_ALLOC_MODE(1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    ovc_status_ctrl #(.V(V), .B(B), .CRDTw(CRDTw), .OVC_ALLOC_MODE(0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CRDTw-1:0] cr(input int i);
        return bus0.credit[i*CRDTw +: CRDTw];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        bus0.credit_in            = '0;
        bus0.buff_space_decreased = '0;
        bus0.ovc_is_allocated     = '0;
        bus0.ovc_is_released      = '0;
    endtask

    task automatic pulse(input logic [V-1:0] cin, input logic [V-1:0] dec,
                         input logic [V-1:0] alloc, input logic [V-1:0] rel);
        bus0.credit_in            = cin;
        bus0.buff_space_decreased = dec;
        bus0.ovc_is_allocated     = alloc;
        bus0.ovc_is_released      = rel;
        tick();
        clear_pulses();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        compared++; if (bus0.credit !== 12'h000) begin mismatched++; $display("FAIL reset_credit got %h exp %h", bus0.credit, 12'h000); end
        compared++; if (bus0.ovc_status !== 4'h0) begin mismatched++; $display("FAIL reset_status got %b exp %b", bus0.ovc_status, 4'h0); end
        compared++; if (bus0.ovc_avalable !== 4'h0) begin mismatched++; $display("FAIL reset_avail got %b exp %b", bus0.ovc_avalable, 4'h0); end
        compared++; if (bus0.full !== 4'hF) begin mismatched++; $display("FAIL reset_full got %b exp %b", bus0.full, 4'hF); end
        compared++; if (bus0.nearly_full !== 4'hF) begin mismatched++; $display("FAIL reset_nfull got %b exp %b", bus0.nearly_full, 4'hF); end
        compared++; if (bus0.empty !== 4'hF) begin mismatched++; $display("FAIL reset_empty got %b exp %b", bus0.empty, 4'hF); end
        compared++; if (bus0.init_done !== 1'b0) begin mismatched++; $display("FAIL reset_init_done got %b exp 0", bus0.init_done); end
        compared++; if (bus0.err !== 3'b000) begin mismatched++; $display("FAIL reset_err got %b exp 000", bus0.err); end
    endtask

    task automatic test_init_capture();
        reset = 1'b0;
        tick();
        compared++; if (bus0.init_done !== 1'b0) begin mismatched++; $display("FAIL init_done_early got %b exp 0", bus0.init_done); end
        tick();
        compared++; if (bus0.init_done !== 1'b1) begin mismatched++; $display("FAIL init_done_rise got %b exp 1", bus0.init_done); end
        compared++; if (bus0.credit !== 12'h89C) begin mismatched++; $display("FAIL init_credit got %h exp %h", bus0.credit, 12'h89C); end
        compared++; if (bus0.ovc_avalable !== 4'hF) begin mismatched++; $display("FAIL init_avail_m1 got %b exp %b", bus0.ovc_avalable, 4'hF); end
        compared++; if (bus1.ovc_avalable !== 4'hF) begin mismatched++; $display("FAIL init_avail_m0 got %b exp %b", bus1.ovc_avalable, 4'hF); end
        compared++; if (bus0.empty !== 4'hF) begin mismatched++; $display("FAIL init_empty got %b exp %b", bus0.empty, 4'hF); end
    endtask

    task automatic test_drain_refill();
        logic [CRDTw-1:0] exp_cr [4];
        exp_cr[0] = 3'd3; exp_cr[1] = 3'd2; exp_cr[2] = 3'd1; exp_cr[3] = 3'd0;
        for (int k = 0; k < 4; k++) begin
            pulse(4'b0000, 4'b0001, 4'b0000, 4'b0000);
            compared++; if (cr(0) !== exp_cr[k]) begin mismatched++; $display("FAIL drain_credit step %0d got %0d exp %0d", k, cr(0), exp_cr[k]); end
            compared++; if (bus0.nearly_full[0] !== (k >= 2)) begin mismatched++; $display("FAIL drain_nfull step %0d got %b", k, bus0.nearly_full[0]); end
            compared++; if (bus0.full[0] !== (k == 3)) begin mismatched++; $display("FAIL drain_full step %0d got %b", k, bus0.full[0]); end
            compared++; if (bus0.ovc_avalable[0] !== (k != 3)) begin mismatched++; $display("FAIL drain_avail_m1 step %0d got %b", k, bus0.ovc_avalable[0]); end
            compared++; if (bus1.ovc_avalable[0] !== (k < 2)) begin mismatched++; $display("FAIL drain_avail_m0 step %0d got %b", k, bus1.ovc_avalable[0]); end
            compared++; if (bus0.empty[0] !== 1'b0) begin mismatched++; $display("FAIL drain_empty step %0d got %b exp 0", k, bus0.empty[0]); end
        end
        for (int k = 0; k < 4; k++) begin
            pulse(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        end
        compared++; if (cr(0) !== 3'd4) begin mismatched++; $display("FAIL refill_credit got %0d exp 4", cr(0)); end
        compared++; if (bus0.empty[0] !== 1'b1) begin mismatched++; $display("FAIL refill_empty got %b exp 1", bus0.empty[0]); end
        compared++; if (bus1.ovc_avalable[0] !== 1'b1) begin mismatched++; $display("FAIL refill_avail_m0 got %b exp 1", bus1.ovc_avalable[0]); end
        compared++; if (bus0.err !== 3'b000) begin mismatched++; $display("FAIL refill_err got %b exp 000", bus0.err); end
    endtask

    task automatic test_simultaneous();
        pulse(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        pulse(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        compared++; if (cr(0) !== 3'd2) begin mismatched++; $display("FAIL simul_pre_credit got %0d exp 2", cr(0)); end
        pulse(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        compared++; if (cr(0) !== 3'd2) begin mismatched++; $display("FAIL simul_credit got %0d exp 2", cr(0)); end
        pulse(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        pulse(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        pulse(4'b0000, 4'b0000, 4'b0010, 4'b0000);
        compared++; if (bus0.ovc_status !== 4'b0010) begin mismatched++; $display("FAIL alloc_status got %b exp 0010", bus0.ovc_status); end
        compared++; if (bus0.ovc_avalable !== 4'b1101) begin mismatched++; $display("FAIL alloc_avail got %b exp 1101", bus0.ovc_avalable); end
        compared++; if (bus0.err !== 3'b000) begin mismatched++; $display("FAIL alloc_err got %b exp 000", bus0.err); end
        // OVC1 is busy, so the re-allocation is also flagged as unavailable
        pulse(4'b0000, 4'b0000, 4'b0010, 4'b0010);
        compared++; if (bus0.ovc_status !== 4'b0010) begin mismatched++; $display("FAIL b2b_status got %b exp 0010", bus0.ovc_status); end
        compared++; if (bus0.err !== 3'b100) begin mismatched++; $display("FAIL b2b_err got %b exp 100", bus0.err); end
        pulse(4'b0000, 4'b0000, 4'b0000, 4'b0010);
        compared++; if (bus0.ovc_status !== 4'b0000) begin mismatched++; $display("FAIL release_status got %b exp 0000", bus0.ovc_status); end
    endtask

    task automatic test_errors();
        for (int k = 0; k < 4; k++) begin
            pulse(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        end
        pulse(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        compared++; if (cr(0) !== 3'd0) begin mismatched++; $display("FAIL underflow_credit got %0d exp 0", cr(0)); end
        compared++; if (bus0.err !== 3'b101) begin mismatched++; $display("FAIL underflow_err got %b exp 101", bus0.err); end
        for (int k = 0; k < 4; k++) begin
            pulse(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        end
        pulse(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        compared++; if (cr(0) !== 3'd4) begin mismatched++; $display("FAIL overflow_credit got %0d exp 4", cr(0)); end
        compared++; if (bus0.err !== 3'b111) begin mismatched++; $display("FAIL overflow_err got %b exp 111", bus0.err); end
        pulse(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        pulse(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        compared++; if (bus0.err !== 3'b111) begin mismatched++; $display("FAIL err_sticky got %b exp 111", bus0.err); end
        compared++; if (bus0.credit !== 12'h89C) begin mismatched++; $display("FAIL err_credit got %h exp %h", bus0.credit, 12'h89C); end
    endtask

    task automatic test_reset_mid();
        pulse(4'b0000, 4'b0000, 4'b0100, 4'b0000);
        pulse(4'b0000, 4'b0100, 4'b0000, 4'b0000);
        compared++; if (cr(2) !== 3'd1) begin mismatched++; $display("FAIL mid_pre_credit got %0d exp 1", cr(2)); end
        compared++; if (bus0.ovc_status !== 4'b0100) begin mismatched++; $display("FAIL mid_pre_status got %b exp 0100", bus0.ovc_status); end
        bus0.credit_init_val = {3'd0, 3'd3, 3'd3, 3'd4};
        reset = 1'b1;
        bus0.credit_in = 4'b0100;
        tick();
        compared++; if (bus0.ovc_status !== 4'b0000) begin mismatched++; $display("FAIL mid_rst_status got %b exp 0000", bus0.ovc_status); end
        compared++; if (bus0.credit !== 12'h000) begin mismatched++; $display("FAIL mid_rst_credit got %h exp 000", bus0.credit); end
        compared++; if (bus0.err !== 3'b000) begin mismatched++; $display("FAIL mid_rst_err got %b exp 000", bus0.err); end
        reset = 1'b0;
        bus0.credit_in            = 4'hF;
        bus0.buff_space_decreased = 4'b0101;
        bus0.ovc_is_allocated     = 4'hF;
        tick();
        compared++; if (bus0.init_done !== 1'b0) begin mismatched++; $display("FAIL mid_init_done got %b exp 0", bus0.init_done); end
        tick();
        clear_pulses();
        compared++; if (bus0.init_done !== 1'b1) begin mismatched++; $display("FAIL mid_run_done got %b exp 1", bus0.init_done); end
        compared++; if (bus0.credit !== 12'h8DC) begin mismatched++; $display("FAIL mid_recapture got %h exp %h", bus0.credit, 12'h8DC); end
        compared++; if (bus0.ovc_status !== 4'b0000) begin mismatched++; $display("FAIL mid_run_status got %b exp 0000", bus0.ovc_status); end
        compared++; if (bus0.err !== 3'b000) begin mismatched++; $display("FAIL mid_run_err got %b exp 000", bus0.err); end
    endtask

    task automatic test_hetero();
        bus0.credit_init_val     = {3'd0, 3'd2, 3'd3, 3'd4};
        bus0.hetero_ovc_presence = 4'b0011;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        compared++; if (bus0.credit !== 12'h01C) begin mismatched++; $display("FAIL het_credit got %h exp %h", bus0.credit, 12'h01C); end
        compared++; if (bus0.ovc_avalable !== 4'b0011) begin mismatched++; $display("FAIL het_avail_m1 got %b exp 0011", bus0.ovc_avalable); end
        compared++; if (bus1.ovc_avalable !== 4'b0011) begin mismatched++; $display("FAIL het_avail_m0 got %b exp 0011", bus1.ovc_avalable); end
        compared++; if (bus0.full !== 4'b1100) begin mismatched++; $display("FAIL het_full got %b exp 1100", bus0.full); end
        compared++; if (bus0.empty !== 4'hF) begin mismatched++; $display("FAIL het_empty got %b exp 1111", bus0.empty); end
        pulse(4'b0000, 4'b0000, 4'b1000, 4'b0000);
        compared++; if (bus0.err !== 3'b100) begin mismatched++; $display("FAIL het_alloc_err got %b exp 100", bus0.err); end
        compared++; if (bus0.ovc_status !== 4'b1000) begin mismatched++; $display("FAIL het_alloc_status got %b exp 1000", bus0.ovc_status); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        bus0.credit_init_val     = {3'd0, 3'd2, 3'd3, 3'd4};
        bus0.hetero_ovc_presence = 4'hF;
        clear_pulses();

        test_reset();
        test_init_capture();
        test_drain_refill();
        test_simultaneous();
        test_errors();
        test_reset_mid();
        test_hetero();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
